// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port RAM between the CPU (C) and debug (D) ports,
// with an exclusive debug lock, a CPU stall and a saturating stall counter.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_locked,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_nx;
    logic last_d, last_d_nx;
    always_comb begin
        state_nx  = state;
        last_d_nx = last_d;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        if (state == LOCKED) begin
            d_gnt     = d_req;
            last_d_nx = 1'b1;
            if (!d_lock) state_nx = IDLE;
        end else begin
            // on a tie the port that did not win last time gets the RAM
            c_gnt = c_req & (~d_req | last_d);
            d_gnt = d_req & (~c_req | ~last_d);
            if (c_gnt) last_d_nx = 1'b0;
            if (d_gnt) last_d_nx = 1'b1;
            if (d_gnt && d_lock) state_nx = LOCKED;
        end
        if (rst) begin
            c_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end
    assign d_locked  = (state == LOCKED);
    assign c_stall   = ~rst & ((c_req & ~c_gnt) | d_locked);
    assign mem_addr  = c_gnt ? c_addr : d_gnt ? d_addr : '0;
    assign mem_wdata = c_gnt ? c_wdata : d_gnt ? d_wdata : '0;
    assign mem_we    = c_gnt ? c_we : (d_gnt & d_we);
    assign c_rdata   = c_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nx;
            last_d   <= last_d_nx;
            c_rvalid <= c_gnt & ~c_we;
            d_rvalid <= d_gnt & ~d_we;
            if (c_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus against a transaction-level model of the arbiter.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c_req = 0, c_we = 0, d_req = 0, d_we = 0, d_lock = 0;
    logic [3:0] c_addr = 0, d_addr = 0;
    logic [7:0] c_wdata = 0, d_wdata = 0;
    logic [7:0] mem_rdata = 0;
    logic c_gnt, c_rvalid, c_stall, d_gnt, d_rvalid, d_locked, mem_we;
    logic [7:0] c_rdata, d_rdata, mem_wdata;
    logic [3:0] mem_addr;
    logic [15:0] stall_cnt;
    logic c_gnt2, c_rvalid2, c_stall2, d_gnt2, d_rvalid2, d_locked2, mem_we2;
    logic [7:0] c_rdata2, d_rdata2, mem_wdata2;
    logic [3:0] mem_addr2;
    logic [1:0] stall_cnt2;
    logic [7:0] ram [16];
    int total = 0, bad = 0;
    logic [7:0] mm [16];
    logic m_lock, m_last_d, pc_v, pd_v;
    logic [7:0] pc_d, pd_d;
    int m_cnt, m_cnt2;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_locked(d_locked),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt)
    );

    mem_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt2), .c_rvalid(c_rvalid2), .c_rdata(c_rdata2), .c_stall(c_stall2),
        .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2), .d_locked(d_locked2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata),
        .stall_cnt(stall_cnt2)
    );

    always #5 clk = ~clk;

    // RAM driven by the main instance: write at posedge, registered read of the presented address
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 1'b0;
        m_last_d = 1'b1;
        pc_v = 1'b0;
        pd_v = 1'b0;
        pc_d = 8'h00;
        pd_d = 8'h00;
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    task automatic step(input logic cr, input logic cw, input logic [3:0] ca, input logic [7:0] cd,
                        input logic dr, input logic dw, input logic dl, input logic [3:0] da,
                        input logic [7:0] dd);
        logic ec, ed, es, ewe, was;
        logic [3:0] ea;
        logic [7:0] ew, ecr, edr;
        @(negedge clk);
        c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
        d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = dd;
        #1;
        if (m_lock) begin
            ec = 1'b0;
            ed = dr;
        end else if (cr && dr) begin
            ec = m_last_d;
            ed = !m_last_d;
        end else begin
            ec = cr;
            ed = dr;
        end
        es  = m_lock | (cr & !ec);
        ea  = ec ? ca : ed ? da : 4'h0;
        ew  = ec ? cd : ed ? dd : 8'h00;
        ewe = ec ? cw : (ed & dw);
        ecr = pc_v ? pc_d : 8'h00;
        edr = pd_v ? pd_d : 8'h00;
        chk("c_gnt", 64'(c_gnt), 64'(ec));
        chk("d_gnt", 64'(d_gnt), 64'(ed));
        chk("c_stall", 64'(c_stall), 64'(es));
        chk("d_locked", 64'(d_locked), 64'(m_lock));
        chk("mem_bus", 64'({mem_addr, mem_wdata, mem_we}), 64'({ea, ew, ewe}));
        chk("c_ret", 64'({c_rvalid, c_rdata}), 64'({pc_v, ecr}));
        chk("d_ret", 64'({d_rvalid, d_rdata}), 64'({pd_v, edr}));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        chk("stall_cnt2", 64'(stall_cnt2), 64'(m_cnt2));
        chk("dut2_bus", 64'({c_gnt2, d_gnt2, c_stall2, d_locked2, mem_addr2, mem_wdata2, mem_we2,
                             c_rvalid2, c_rdata2, d_rvalid2, d_rdata2}),
                        64'({ec, ed, es, m_lock, ea, ew, ewe, pc_v, ecr, pd_v, edr}));
        @(posedge clk);
        pc_v = ec & !cw;
        pc_d = mm[ca];
        pd_v = ed & !dw;
        pd_d = mm[da];
        if (ec && cw) mm[ca] = cd;
        if (ed && dw) mm[da] = dd;
        if (es) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        was = m_lock;
        if (m_lock) begin
            if (!dl) m_lock = 1'b0;
        end else if (ed && dl) m_lock = 1'b1;
        if (ec) m_last_d = 1'b0;
        if (ed || was) m_last_d = 1'b1;
    endtask

    // reset asserted mid-cycle with both requesters active: everything must read as idle
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        c_req = 1'b1; d_req = 1'b1; c_we = 1'b0; d_we = 1'b0; d_lock = 1'b1;
        model_reset();
        #1;
        chk("rst_gnt", 64'({c_gnt, d_gnt, mem_we, c_stall, d_locked}), 64'(0));
        chk("rst_ret", 64'({c_rvalid, c_rdata, d_rvalid, d_rdata}), 64'(0));
        chk("rst_cnt", 64'({stall_cnt, stall_cnt2}), 64'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        c_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
    endtask

    initial begin
        logic lk;
        logic [31:0] r;
        model_reset();
        do_reset();
        // back-to-back contention right after reset: C,D,C,D
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 4'(i), 8'(i), 1'b1, 1'b1, 1'b0, 4'(i + 8), 8'(i + 8));
        // load the whole RAM from the debug port
        for (int i = 0; i < 16; i++)
            step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 4'(i), 8'($urandom));
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd3, 8'h2A);
        step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        // debug write then immediate read-back of the same word
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd5, 8'h7F);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd5, 8'h00);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        // locked upload while the CPU keeps requesting; the C-only cycle hands the next tie to D
        step(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 1'b1, 1'b1, 4'(i), 8'(8'h11 + i));
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        // reset in the cycle where a read return is due, then a tie goes to C
        step(1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        do_reset();
        step(1'b1, 1'b0, 4'd1, 8'h00, 1'b1, 1'b0, 1'b0, 4'd2, 8'h00);
        step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
        lk = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            if (r[31:29] == 3'd0) lk = ~lk;
            step(r[0], r[1], r[5:2], r[13:6], r[14], r[15], lk, r[19:16], r[27:20]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
